myrisc16_mem_arb: RTL and testbench
===================================

# myrisc16_mem_arb

Arbiter sharing the single-port 16-bit word memory of the myrisc16 core between three requesters: host loader (0), data load/store (1), instruction fetch (2). Sits between the core's split fetch/data ports plus the loader, and one synchronous-read memory macro. Provides fixed priority with fetch anti-starvation, plus a loader lock mode that stalls the core while a program image is written.

## Interface
- ADDR_W, 16, address width in words
- DATA_W, 16, data width
- STARVE_LIMIT, 4, consecutive lost cycles before fetch is promoted (legal 1..15)

- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- req  in  3  per-requester access request, index 0=loader 1=dmem 2=imem
- we  in  3  per-requester write enable (1=write)
- addr  in  3*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  per-requester write data, same packing
- lock_req  in  1  loader requests exclusive ownership
- gnt  out  3  one-hot grant, combinational, same cycle as req
- rvalid  out  3  one-hot read-data valid, one cycle after a read grant
- rdata  out  DATA_W  shared read data, meaningful only with rvalid
- cpu_stall  out  1  high while in LOCK state
- mem_en, mem_we  out  1  memory enable / write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en && !mem_we

## Operation
- States: RUN, LOCK. Reset -> RUN.
- RUN priority: loader > dmem > imem; imem promoted above dmem (never above loader) when starve count == STARVE_LIMIT.
- LOCK: only requester 0 can be granted; req[1], req[2] ignored, gnt[1:0]... gnt[2:1]=0.
- RUN -> LOCK: lock_req && gnt[0] in the same cycle. lock_req without req[0]: no transition.
- LOCK -> RUN: lock_req low at a clock edge. The grant in the cycle lock_req drops still follows LOCK rules.
- Starve counter: increments (saturating at STARVE_LIMIT) when req[2] && !gnt[2] in RUN; clears when gnt[2], !req[2], or in LOCK.
- At most one gnt bit per cycle. The memory port is driven from the granted requester: mem_en=|gnt, mem_we=we[i], mem_addr/wdata from slot i. Signals are zero when idle.
- Requester holds req/we/addr/wdata stable until it sees gnt. It may keep req high for back-to-back accesses. Each gnt cycle is exactly one access.
- Read grant on requester i at cycle N -> rvalid[i]=1 at N+1, rdata=mem_rdata. A write grant produces no rvalid.

## Timing
- Grant and memory command latency: 0 cycles (combinational). Read data latency: 1 cycle. Throughput: one access per cycle.
- Reset values: gnt=0, rvalid=0, cpu_stall=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata follows mem_rdata. State RUN, counter 0.
- Reset mid-operation: an rvalid pending from the prior cycle is suppressed. The LOCK state and counter clear on the reset edge.
- Simultaneous req on all three with counter < limit: loader wins and the counter increments. The same case with counter == limit: loader wins and the counter holds.
- cpu_stall is registered from the state and asserts the cycle after the lock grant.

## Configuration
- MYRISC16_ARB_STARVE_EN defined: starve counter and imem promotion are present as described.
- MYRISC16_ARB_STARVE_EN undefined: pure fixed priority loader > dmem > imem. No counter is built and STARVE_LIMIT is ignored.

## Structure
- Package myrisc16_pkg holds:
  - requester index constants REQ_LDR=0, REQ_DMEM=1, REQ_IMEM=2
  - arb state typedef {RUN, LOCK}
  - shared ADDR_W/DATA_W defaults
- One sub-module, myrisc16_starve_cnt: a saturating counter with inc/clr/limit and a `hit` output. It is instantiated only under MYRISC16_ARB_STARVE_EN.

## Test plan
- Reset, then dmem read addr 0x0010 with mem holding 0xBEEF -> gnt=3'b010 same cycle; rvalid=3'b010 and rdata=0xBEEF next cycle.
- dmem and imem both requesting continuously, STARVE_LIMIT=4 -> gnt pattern dmem×4, imem×1, repeating. Without the macro -> dmem only.
- Loader write 0x1234 to 0x0000 with lock_req=1 while dmem/imem request -> gnt=3'b001, cpu_stall=1 next cycle. dmem/imem are not granted until lock_req drops, then dmem is granted first.
- lock_req=1 with req[0]=0 -> state stays RUN, cpu_stall=0, dmem/imem served normally.
- imem read granted, then rstn=0 on the next cycle -> rvalid stays 0 and gnt=0. After release, the counter is 0 and the state is RUN.
- Back-to-back loader writes to 0x0000..0x0003 followed by imem reads of the same addresses -> rdata 0x1234, ... each exactly one cycle after its grant.

Source files
------------

// File: rtl/myrisc16_pkg.sv
// myrisc16_pkg: shared constants and types for the myrisc16 memory arbiter.
`default_nettype none

package myrisc16_pkg;

  localparam int REQ_LDR    = 0;
  localparam int REQ_DMEM   = 1;
  localparam int REQ_IMEM   = 2;
  localparam int NUM_REQ    = 3;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/myrisc16_starve_cnt.sv
// myrisc16_starve_cnt: saturating counter, clear has priority, hit when count == limit.
`default_nettype none

module myrisc16_starve_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      count <= '0;
    end else if (inc && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == limit);

endmodule

`default_nettype wire

// File: rtl/myrisc16_mem_arb.sv
// myrisc16_mem_arb: 3-way single-port memory arbiter (loader > dmem > imem) with loader lock.
// Optional fetch anti-starvation promotion is built when MYRISC16_ARB_STARVE_EN is defined.
`default_nettype none

module myrisc16_mem_arb
  import myrisc16_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  input  logic                  lock_req,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  cpu_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_t state;
  logic       stall_q;
  logic [2:0] rvalid_q;
  logic [2:0] arb_gnt;
  logic       promote;

`ifdef MYRISC16_ARB_STARVE_EN
  logic cnt_inc;
  logic cnt_clr;
  logic starve_hit;

  assign cnt_inc = (state == RUN) && req[REQ_IMEM] && !gnt[REQ_IMEM];
  assign cnt_clr = (state == LOCK) || gnt[REQ_IMEM] || !req[REQ_IMEM];

  myrisc16_starve_cnt #(
    .W(4)
  ) u_starve_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .limit (4'(STARVE_LIMIT)),
    .hit   (starve_hit)
  );

  assign promote = starve_hit;
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    arb_gnt = '0;
    if (state == LOCK) begin
      arb_gnt[REQ_LDR] = req[REQ_LDR];
    end else if (req[REQ_LDR]) begin
      arb_gnt[REQ_LDR] = 1'b1;
    end else if (promote && req[REQ_IMEM]) begin
      arb_gnt[REQ_IMEM] = 1'b1;
    end else if (req[REQ_DMEM]) begin
      arb_gnt[REQ_DMEM] = 1'b1;
    end else if (req[REQ_IMEM]) begin
      arb_gnt[REQ_IMEM] = 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held, including an rvalid already in flight.
  assign gnt       = rstn ? arb_gnt : 3'b000;
  assign rvalid    = rvalid_q & {3{rstn}};
  assign cpu_stall = stall_q & rstn;
  assign rdata     = mem_rdata;
  assign mem_en    = |gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= RUN;
      stall_q  <= 1'b0;
      rvalid_q <= 3'b000;
    end else begin
      rvalid_q <= gnt & ~we;
      case (state)
        RUN: begin
          if (lock_req && gnt[REQ_LDR]) begin
            state   <= LOCK;
            stall_q <= 1'b1;
          end
        end
        LOCK: begin
          if (!lock_req) begin
            state   <= RUN;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_myrisc16_mem_arb.sv
// tb_myrisc16_mem_arb: directed + random stimulus, reference model feeds a scoreboard checked by a monitor.
`default_nettype none

module tb_myrisc16_mem_arb;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 4;
`ifdef MYRISC16_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [2:0]      req = '0;
  logic [2:0]      we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic            lock_req = 1'b0;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            cpu_stall;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  myrisc16_mem_arb #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lock_req(lock_req), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .cpu_stall(cpu_stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory macro attached to the DUT port.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic        stall;
    logic        en;
    logic        mwe;
    logic [15:0] maddr;
    logic [15:0] mwdata;
  } exp_t;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] ref_mem [0:65535];
  bit          m_lock = 1'b0;
  int          m_cnt = 0;
  logic [2:0]  pend_rv = 3'b000;
  rd_t         pend_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [47:0] pk(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
    return {s2, s1, s0};
  endfunction

  // One clock cycle: drive inputs, predict the response from the arbitration rules, advance.
  task automatic step(input logic rn, input logic [2:0] r, input logic [2:0] w,
                      input logic [47:0] a, input logic [47:0] d, input logic lk,
                      output logic [2:0] g);
    exp_t e;
    int   win;
    rstn = rn; req = r; we = w; addr = a; wdata = d; lock_req = lk;
    win = -1;
    if (rn) begin
      if (m_lock)                                win = r[0] ? 0 : -1;
      else if (r[0])                             win = 0;
      else if (STARVE && r[2] && m_cnt == LIMIT) win = 2;
      else if (r[1])                             win = 1;
      else if (r[2])                             win = 2;
    end
    g = (win < 0) ? 3'b000 : 3'(1 << win);
    e.gnt    = g;
    e.rvalid = rn ? pend_rv : 3'b000;
    e.stall  = rn && m_lock;
    e.en     = (win >= 0);
    e.mwe    = (win >= 0) ? w[win] : 1'b0;
    e.maddr  = (win >= 0) ? a[win*16 +: 16] : 16'h0;
    e.mwdata = (win >= 0) ? d[win*16 +: 16] : 16'h0;
    if (rn && pend_rv != 0) rd_q.push_back(pend_rd);
    pend_rv = 3'b000;
    if (win >= 0) begin
      if (w[win]) ref_mem[a[win*16 +: 16]] = d[win*16 +: 16];
      else begin
        pend_rv      = g;
        pend_rd.idx  = win;
        pend_rd.data = ref_mem[a[win*16 +: 16]];
      end
    end
    if (!rn) begin
      m_lock = 1'b0; m_cnt = 0; pend_rv = 3'b000;
    end else begin
      if (m_lock || !r[2] || win == 2) m_cnt = 0;
      else if (m_cnt < LIMIT)          m_cnt++;
      if (!m_lock && lk && win == 0)   m_lock = 1'b1;
      else if (m_lock && !lk)          m_lock = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per cycle and read data whenever rvalid shows.
  initial begin
    exp_t e;
    rd_t  rd;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("rvalid", 32'(rvalid), 32'(e.rvalid));
        chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
        chk("mem_cmd", {13'h0, mem_en, mem_we, 1'b0, mem_addr}, {13'h0, e.en, e.mwe, 1'b0, e.maddr});
        chk("mem_wdata", 32'(mem_wdata), 32'(e.mwdata));
      end
      if (rvalid != 0) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rvalid", 32'(rvalid), 32'h0);
        end else begin
          rd = rd_q.pop_front();
          chk("rvalid_idx", 32'(rvalid), 32'(1 << rd.idx));
          chk("rdata", 32'(rdata), 32'(rd.data));
        end
      end
    end
  end

  initial begin
    logic [2:0]  g;
    bit          pv [3];
    logic        pw [3];
    logic [15:0] pa [3];
    logic [15:0] pd [3];
    logic [2:0]  r, w;
    int          lk_left;

    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'(i * 3) ^ 16'h5A00;
      ref_mem[i] = 16'(i * 3) ^ 16'h5A00;
    end
    ram[16'h0010]     = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;

    @(posedge clk); #1;
    repeat (3) step(1'b0, 3'b000, 3'b000, '0, '0, 1'b0, g);

    // dmem read of 0x0010
    step(1'b1, 3'b010, 3'b000, pk(0, 16'h0010, 0), '0, 1'b0, g);
    step(1'b1, 3'b000, 3'b000, '0, '0, 1'b0, g);

    // dmem and imem both requesting continuously
    repeat (12) step(1'b1, 3'b110, 3'b000, pk(0, 16'h0020, 16'h0030), '0, 1'b0, g);

    // Loader locked write while the core requests
    step(1'b1, 3'b111, 3'b001, pk(0, 16'h0021, 16'h0031), pk(16'h1234, 0, 0), 1'b1, g);
    repeat (3) step(1'b1, 3'b110, 3'b000, pk(0, 16'h0021, 16'h0031), '0, 1'b1, g);
    repeat (3) step(1'b1, 3'b110, 3'b000, pk(0, 16'h0021, 16'h0031), '0, 1'b0, g);

    // lock_req without a loader request
    repeat (4) step(1'b1, 3'b110, 3'b000, pk(0, 16'h0022, 16'h0032), '0, 1'b1, g);

    // imem read then reset on the following cycle
    step(1'b1, 3'b100, 3'b000, pk(0, 0, 16'h0040), '0, 1'b0, g);
    step(1'b0, 3'b100, 3'b000, pk(0, 0, 16'h0040), '0, 1'b0, g);
    step(1'b1, 3'b000, 3'b000, '0, '0, 1'b0, g);

    // Back-to-back loader writes then imem reads of the same words
    for (int k = 0; k < 4; k++)
      step(1'b1, 3'b001, 3'b001, pk(16'(k), 0, 0), pk(16'h1234 + 16'(k), 0, 0), 1'b0, g);
    for (int k = 0; k < 4; k++)
      step(1'b1, 3'b100, 3'b000, pk(0, 0, 16'(k)), '0, 1'b0, g);
    step(1'b1, 3'b000, 3'b000, '0, '0, 1'b0, g);

    // Random traffic with hold-until-granted requesters
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    lk_left = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && ($urandom_range(99) < ((i == 0) ? 25 : 60))) begin
          pv[i] = 1'b1;
          pw[i] = $urandom_range(1);
          pa[i] = 16'($urandom_range(15));
          pd[i] = 16'($urandom);
        end
      end
      if (lk_left == 0 && $urandom_range(29) == 0) lk_left = $urandom_range(8, 1);
      for (int i = 0; i < 3; i++) begin
        r[i] = pv[i];
        w[i] = pv[i] ? pw[i] : 1'b0;
      end
      step(($urandom_range(299) != 0), r, w, pk(pa[0], pa[1], pa[2]),
           pk(pd[0], pd[1], pd[2]), (lk_left > 0), g);
      if (lk_left > 0) lk_left--;
      for (int i = 0; i < 3; i++) if (g[i]) pv[i] = 1'b0;
    end

    repeat (2) step(1'b1, 3'b000, 3'b000, '0, '0, 1'b0, g);
    @(negedge clk); #1;
    chk("pending_reads", 32'(rd_q.size()), 32'h0);
    chk("pending_cycles", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
